// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: default widths and the skid buffer depth.
package fifo_pkg;

    localparam int BITS_DEFAULT = 8;
    localparam int CNTW_DEFAULT = 16;
    localparam int SKID_DEPTH   = 2;

    // Occupancy of the skid buffer, 0..SKID_DEPTH.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry in-order buffer: entry 0 is always the head, a pop shifts entries toward it.
// Asynchronous active-low reset clears the contents and occupancy.
module reader_skid_buf
    import fifo_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [BITS-1:0] din,
    input  logic            pop,
    output occ_t            occ,
    output logic [BITS-1:0] head
);

    logic [BITS-1:0] mem_reg [SKID_DEPTH];
    occ_t            occ_reg;
    occ_t            occ_after_pop;
    logic            pop_ok;

    // A pop against an empty buffer is ignored so occupancy can never underflow.
    assign pop_ok        = pop && (occ_reg != '0);
    assign occ_after_pop = occ_reg - {1'b0, pop_ok};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_after_pop + {1'b0, wr};
        end
    end

    // The write lands in the slot just past the remaining words after the pop.
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
        logic [BITS-1:0] shift_val;

        if (gi < SKID_DEPTH - 1) begin : g_mid
            assign shift_val = mem_reg[gi + 1];
        end else begin : g_last
            assign shift_val = mem_reg[gi];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_reg[gi] <= '0;
            end else if (wr && (occ_after_pop == occ_t'(gi))) begin
                mem_reg[gi] <= din;
            end else if (pop_ok) begin
                mem_reg[gi] <= shift_val;
            end
        end
    end

    assign occ  = occ_reg;
    assign head = mem_reg[0];

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO read port into a valid/ready stream via a 2-entry skid buffer.
// Define FIFO_READER_COUNT_EN to enable the accepted-word counter on count.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,   // active low, asynchronous
    input  logic            empty,
    output logic            re,
    input  logic [BITS-1:0] q,
    output logic [BITS-1:0] dout,
    output logic            dvalid,
    input  logic            dready,
    output logic [CNTW-1:0] count
);

    logic       infl_reg;
    logic       pop;
    occ_t       occ;
    logic [2:0] pending;

    reader_skid_buf #(
        .BITS (BITS)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .wr    (infl_reg),
        .din   (q),
        .pop   (pop),
        .occ   (occ),
        .head  (dout)
    );

    assign dvalid  = (occ != '0);
    assign pop     = dvalid && dready;
    assign pending = {1'b0, occ} + {2'b00, infl_reg} - {2'b00, pop};

    // Gating with reset keeps re low immediately, before any clock edge.
    always_comb begin
        re = 1'b0;
        if (reset && !empty && (pending < 3'(SKID_DEPTH))) begin
            re = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            infl_reg <= 1'b0;
        end else begin
            infl_reg <= re;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [CNTW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
`else
    assign count = '0;
`endif

endmodule
